branch_predictor_btb: RTL

Parametrised dynamic branch predictor combining a direct-mapped branch history table of 2-bit saturating counters with a tagged branch target buffer. It makes a taken/not-taken and target prediction for the branch currently in ID. It resolves the branch in the ALU stage, raising a flush and a corrected PC on mispredict, and updates its tables on the clock edge. It replaces the fixed 8-entry, untagged, target-less predictor in the hazard-handling units and adds aliasing detection, target prediction and a misprediction counter.

---
 rtl/branch_predictor_btb_pkg.sv | 29 ++
 rtl/branch_predictor_btb_entry_array.sv | 62 ++++++
 rtl/branch_predictor_btb.sv | 110 +++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the branch predictor: counter encodings, PC increment
// and the helpers that split a PC into table index and tag.
package branch_predictor_btb_pkg;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  localparam int BP_PC_INC = 4;
  localparam int BP_PC_MAX = 64;

  // Word-aligned PCs: bits [1:0] never take part in indexing.
  function automatic logic [31:0] bp_index(input logic [BP_PC_MAX-1:0] pc,
                                           input int index_bits);
    logic [BP_PC_MAX-1:0] mask;
    mask = (64'd1 << index_bits) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  function automatic logic [31:0] bp_tag(input logic [BP_PC_MAX-1:0] pc,
                                         input int index_bits,
                                         input int tag_bits);
    logic [BP_PC_MAX-1:0] mask;
    mask = (64'd1 << tag_bits) - 64'd1;
    return 32'((pc >> (index_bits + 2)) & mask);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_entry_array.sv
// Predictor table storage: two asynchronous read ports (ID, ALU) and one
// synchronous write port; a write always marks the entry valid.
module bp_entry_array
  import branch_predictor_btb_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 8,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [INDEX_BITS-1:0] i_id_idx,
  output logic                  o_id_valid,
  output logic [TAG_BITS-1:0]   o_id_tag,
  output logic [1:0]            o_id_cnt,
  output logic [PC_WIDTH-1:0]   o_id_target,
  input  logic [INDEX_BITS-1:0] i_ex_idx,
  output logic                  o_ex_valid,
  output logic [TAG_BITS-1:0]   o_ex_tag,
  output logic [1:0]            o_ex_cnt,
  output logic [PC_WIDTH-1:0]   o_ex_target,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [1:0]            i_wr_cnt,
  input  logic [PC_WIDTH-1:0]   i_wr_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [1:0]          r_cnt    [ENTRIES];
  logic [PC_WIDTH-1:0] r_target [ENTRIES];

  assign o_id_valid  = r_valid[i_id_idx];
  assign o_id_tag    = r_tag[i_id_idx];
  assign o_id_cnt    = r_cnt[i_id_idx];
  assign o_id_target = r_target[i_id_idx];

  assign o_ex_valid  = r_valid[i_ex_idx];
  assign o_ex_tag    = r_tag[i_ex_idx];
  assign o_ex_cnt    = r_cnt[i_ex_idx];
  assign o_ex_target = r_target[i_ex_idx];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_cnt[i]    <= CNT_WNT;
        r_target[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_valid[i_wr_idx]  <= 1'b1;
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_cnt[i_wr_idx]    <= i_wr_cnt;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor: 2-bit counter history table plus tagged target
// buffer; predicts in ID, resolves in ALU and counts mispredictions.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 8,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_id_branch,
  input  logic [PC_WIDTH-1:0]  i_id_pc,
  input  logic                 i_ex_branch,
  input  logic [PC_WIDTH-1:0]  i_ex_pc,
  input  logic                 i_ex_taken,
  input  logic [PC_WIDTH-1:0]  i_ex_target,
  input  logic                 i_ex_pred_taken,
  input  logic [PC_WIDTH-1:0]  i_ex_pred_target,
  output logic                 o_predict_taken,
  output logic [PC_WIDTH-1:0]  o_predict_target,
  output logic                 o_flush,
  output logic [PC_WIDTH-1:0]  o_redirect_pc,
  output logic [CNT_WIDTH-1:0] o_mispredict_count
);

  logic [INDEX_BITS-1:0] w_id_idx, w_ex_idx;
  logic [TAG_BITS-1:0]   w_id_pc_tag, w_ex_pc_tag;
  logic                  w_id_valid, w_ex_valid;
  logic [TAG_BITS-1:0]   w_id_tag, w_ex_tag;
  logic [1:0]            w_id_cnt, w_ex_cnt;
  logic [PC_WIDTH-1:0]   w_id_target, w_ex_target;
  logic                  w_id_hit, w_ex_hit;
  logic                  w_flush;
  logic                  w_wr_en;
  logic [1:0]            w_wr_cnt;
  logic [PC_WIDTH-1:0]   w_wr_target;
  logic [CNT_WIDTH-1:0]  r_mispredict_count;

  assign w_id_idx    = INDEX_BITS'(bp_index(BP_PC_MAX'(i_id_pc), INDEX_BITS));
  assign w_ex_idx    = INDEX_BITS'(bp_index(BP_PC_MAX'(i_ex_pc), INDEX_BITS));
  assign w_id_pc_tag = TAG_BITS'(bp_tag(BP_PC_MAX'(i_id_pc), INDEX_BITS, TAG_BITS));
  assign w_ex_pc_tag = TAG_BITS'(bp_tag(BP_PC_MAX'(i_ex_pc), INDEX_BITS, TAG_BITS));

  bp_entry_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .PC_WIDTH   (PC_WIDTH)
  ) u_entries (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_id_idx    (w_id_idx),
    .o_id_valid  (w_id_valid),
    .o_id_tag    (w_id_tag),
    .o_id_cnt    (w_id_cnt),
    .o_id_target (w_id_target),
    .i_ex_idx    (w_ex_idx),
    .o_ex_valid  (w_ex_valid),
    .o_ex_tag    (w_ex_tag),
    .o_ex_cnt    (w_ex_cnt),
    .o_ex_target (w_ex_target),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_ex_idx),
    .i_wr_tag    (w_ex_pc_tag),
    .i_wr_cnt    (w_wr_cnt),
    .i_wr_target (w_wr_target)
  );

  assign w_id_hit = w_id_valid & (w_id_tag == w_id_pc_tag);
  assign w_ex_hit = w_ex_valid & (w_ex_tag == w_ex_pc_tag);

  assign w_flush = i_ex_branch & ~i_reset &
                   ((i_ex_taken != i_ex_pred_taken) |
                    (i_ex_taken & i_ex_pred_taken & (i_ex_target != i_ex_pred_target)));

  // The ID instruction is younger than a mispredicted branch, so it never redirects.
  assign o_predict_taken  = i_id_branch & w_id_hit & w_id_cnt[1] & ~w_flush & ~i_reset;
  assign o_predict_target = o_predict_taken ? w_id_target : '0;

  assign o_flush       = w_flush;
  assign o_redirect_pc = !w_flush    ? '0 :
                         i_ex_taken ? i_ex_target : i_ex_pc + PC_WIDTH'(BP_PC_INC);

  assign w_wr_en = i_ex_branch & ~i_reset;

  always_comb begin
    w_wr_cnt    = i_ex_taken ? CNT_WT : CNT_WNT;
    w_wr_target = i_ex_target;
    if (w_ex_hit) begin
      if (i_ex_taken) begin
        w_wr_cnt = (w_ex_cnt == CNT_ST) ? CNT_ST : w_ex_cnt + 2'd1;
      end else begin
        w_wr_cnt    = (w_ex_cnt == CNT_SNT) ? CNT_SNT : w_ex_cnt - 2'd1;
        w_wr_target = w_ex_target;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mispredict_count <= '0;
    end else if (w_flush && (r_mispredict_count != '1)) begin
      r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
    end
  end

  assign o_mispredict_count = r_mispredict_count;

endmodule
